multiplier: RTL and testbench

MULTIPLIER -- requirements
Module: multiplier

---
 rtl/multiplier_if.sv | 20 ++
 rtl/multiplier.sv | 75 +++++++
 tb/tb_multiplier.sv | 137 +++++++++++++
 3 files changed

// File: rtl/multiplier_if.sv
// multiplier_if: operand/result handshake bundle for the shift-and-add multiplier.
interface multiplier_if #(parameter int DATA_WIDTH = 8);
    logic [DATA_WIDTH-1:0]   multiplicand_in;
    logic [DATA_WIDTH-1:0]   multiplier_in;
    logic [DATA_WIDTH-1:0]   addend_in;
    logic                    valid_in;
    logic                    ready_out;
    logic [2*DATA_WIDTH-1:0] product_out;
    logic                    overflow_out;
    logic                    valid_out;
    logic                    ready_in;
    modport slave (
        input  multiplicand_in, multiplier_in, addend_in, valid_in, ready_in,
        output ready_out, product_out, overflow_out, valid_out
    );
    modport master (
        output multiplicand_in, multiplier_in, addend_in, valid_in, ready_in,
        input  ready_out, product_out, overflow_out, valid_out
    );
endinterface

// File: rtl/multiplier.sv
// multiplier: radix-2 shift-and-add A*B+C, one multiplier bit per cycle, fixed latency.
module multiplier #(
    parameter int DATA_WIDTH = 8
) (
    input logic         clk,
    input logic         rst_n,
    multiplier_if.slave bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t           state_q;
    logic [W-1:0]     a_q, b_q;
    logic [CW-1:0]    cnt_q;
    logic [2*W-1:0]   acc_q, acc_d, step;
    logic             ready_q, valid_q, overflow_q;
    logic [2*W-1:0]   product_q;
    logic             last;
    always_comb begin
        step  = b_q[cnt_q] ? ({{W{1'b0}}, a_q} << cnt_q) : '0;
        acc_d = acc_q + step;
        last  = cnt_q == CW'(W - 1);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            ready_q    <= 1'b0;
            valid_q    <= 1'b0;
            product_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (bus.valid_in && ready_q) begin
                        a_q     <= bus.multiplicand_in;
                        b_q     <= bus.multiplier_in;
                        acc_q   <= {{W{1'b0}}, bus.addend_in};
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (last) begin
                        state_q    <= DONE;
                        valid_q    <= 1'b1;
                        product_q  <= acc_d;
                        overflow_q <= |acc_d[2*W-1:W];
                    end
                end
                DONE: begin
                    if (bus.ready_in) begin
                        state_q    <= IDLE;
                        valid_q    <= 1'b0;
                        product_q  <= '0;
                        overflow_q <= 1'b0;
                        ready_q    <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.ready_out    = ready_q;
    assign bus.valid_out    = valid_q;
    assign bus.product_out  = product_q;
    assign bus.overflow_out = overflow_q;
endmodule

// File: tb/tb_multiplier.sv
// tb_multiplier: directed and randomized checks of multiplier against plain A*B+C arithmetic.
module tb_multiplier;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fails = 0;
    always #5 clk = ~clk;
    multiplier_if #(.DATA_WIDTH(W)) bus ();
    multiplier #(.DATA_WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic start(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
        int n = 0;
        while (!bus.ready_out && n < 20) begin
            tick();
            n++;
        end
        check("ready_before_accept", 32'(bus.ready_out), 1);
        bus.multiplicand_in = a;
        bus.multiplier_in   = b;
        bus.addend_in       = c;
        bus.valid_in        = 1'b1;
        tick();
        bus.valid_in = 1'b0;
        check("ready_drops_on_accept", 32'(bus.ready_out), 0);
    endtask
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                          input int hold, input bit toggle);
        int n = 0;
        logic [2*W-1:0] exp_p;
        logic exp_o;
        exp_p = 16'(int'(a) * int'(b) + int'(c));
        exp_o = (exp_p >> W) != 0;
        bus.ready_in = (hold == 0);
        start(a, b, c);
        while (!bus.valid_out && n < 40) begin
            check("busy_product_zero", 32'(bus.product_out), 0);
            if (toggle) begin
                bus.multiplicand_in = W'($urandom);
                bus.multiplier_in   = W'($urandom);
                bus.addend_in       = W'($urandom);
                bus.valid_in        = $urandom_range(0, 1) == 1;
            end
            tick();
            n++;
        end
        bus.valid_in = 1'b0;
        check("latency", 32'(n), W);
        check("product", 32'(bus.product_out), 32'(exp_p));
        check("overflow", 32'(bus.overflow_out), 32'(exp_o));
        check("ready_low_in_done", 32'(bus.ready_out), 0);
        repeat (hold) begin
            tick();
            check("hold_valid", 32'(bus.valid_out), 1);
            check("hold_product", 32'(bus.product_out), 32'(exp_p));
            check("hold_overflow", 32'(bus.overflow_out), 32'(exp_o));
        end
        bus.ready_in = 1'b1;
        tick();
        bus.ready_in = 1'b0;
        check("release_valid", 32'(bus.valid_out), 0);
        check("release_product", 32'(bus.product_out), 0);
        check("release_overflow", 32'(bus.overflow_out), 0);
        check("release_ready", 32'(bus.ready_out), 1);
        if (toggle) begin
            repeat (5) begin
                tick();
                check("no_second_result", 32'(bus.valid_out), 0);
            end
        end
    endtask
    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(bus.ready_out), 0);
        check({tag, "_valid"}, 32'(bus.valid_out), 0);
        check({tag, "_product"}, 32'(bus.product_out), 0);
        check({tag, "_overflow"}, 32'(bus.overflow_out), 0);
    endtask
    task automatic release_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
        check("ready_before_first_edge", 32'(bus.ready_out), 0);
        tick();
        check("ready_after_first_edge", 32'(bus.ready_out), 1);
    endtask
    initial begin
        int n;
        bus.multiplicand_in = '0;
        bus.multiplier_in   = '0;
        bus.addend_in       = '0;
        bus.valid_in        = 1'b0;
        bus.ready_in        = 1'b0;
        #1 check_all_zero("reset");
        bus.valid_in = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset_held");
        bus.valid_in = 1'b0;
        release_reset();
        run_op(13, 11, 5, 0, 0);
        run_op(255, 255, 254, 3, 0);
        run_op(0, 200, 0, 0, 0);
        run_op(7, 0, 9, 0, 0);
        run_op(13, 11, 5, 20, 0);
        run_op(50, 60, 70, 2, 1);
        // abort mid-computation: reset lands between edges in the fourth BUSY cycle
        start(100, 200, 7);
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1 check_all_zero("abort_busy");
        release_reset();
        start(200, 150, 99);
        n = 0;
        while (!bus.valid_out && n < 40) begin
            tick();
            n++;
        end
        check("done_before_abort", 32'(bus.valid_out), 1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("abort_done");
        release_reset();
        run_op(3, 4, 1, 0, 0);
        repeat (30) begin
            run_op(W'($urandom), W'($urandom), W'($urandom), $urandom_range(0, 3), $urandom_range(0, 1) == 1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
